// File: rtl/ldpc_cnu_pkg.sv
// Shared definitions for the check-node unit: default geometry, C2V message
// record and the message-generator FSM states.
package ldpc_cnu_pkg;

   localparam int unsigned CN_DEGREE          = 10;
   localparam int unsigned QUAN_SIZE          = 3;
   localparam int unsigned MIN_INDEX_BITWIDTH = $clog2(CN_DEGREE);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } cnu_state_t;

   typedef struct packed {
      logic                          sign;
      logic [QUAN_SIZE-1:0]          mag;
      logic [MIN_INDEX_BITWIDTH-1:0] index;
      logic                          last;
   } c2v_msg_t;

endpackage

// File: rtl/c2v_mag_sel.sv
// Per-edge C2V select: the min-index edge takes the second minimum, every
// other edge the minimum; sign is the total parity with the edge's own sign removed.
module c2v_mag_sel #(
   parameter int unsigned QUAN_SIZE          = ldpc_cnu_pkg::QUAN_SIZE,
   parameter int unsigned MIN_INDEX_BITWIDTH = ldpc_cnu_pkg::MIN_INDEX_BITWIDTH
) (
   input  logic [MIN_INDEX_BITWIDTH-1:0] cnt_i,
   input  logic [MIN_INDEX_BITWIDTH-1:0] min_1_index_i,
   input  logic [QUAN_SIZE-1:0]          m1_i,
   input  logic [QUAN_SIZE-1:0]          m2_i,
   input  logic                          parity_i,
   input  logic                          sign_bit_i,
   output logic                          sign_o,
   output logic [QUAN_SIZE-1:0]          mag_o
);

   assign sign_o = parity_i ^ sign_bit_i;
   assign mag_o  = (cnt_i == min_1_index_i) ? m2_i : m1_i;

endmodule

// File: rtl/c2v_msg_gen_10.sv
// Degree-10 C2V message generator: captures one CN min-finder result and
// streams its edges under valid/ready. Offset min-sum enabled by OFFSET_MS_EN.
module c2v_msg_gen_10 #(
   parameter int unsigned CN_DEGREE          = ldpc_cnu_pkg::CN_DEGREE,
   parameter int unsigned QUAN_SIZE          = ldpc_cnu_pkg::QUAN_SIZE,
   parameter int unsigned MIN_INDEX_BITWIDTH = $clog2(CN_DEGREE),
   parameter int unsigned OFFSET             = 1
) (
   input  logic                          sys_clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [QUAN_SIZE-1:0]          m1,
   input  logic [QUAN_SIZE-1:0]          m2,
   input  logic [MIN_INDEX_BITWIDTH-1:0] min_1_index,
   input  logic [CN_DEGREE-1:0]          v2c_sign,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          c2v_sign,
   output logic [QUAN_SIZE-1:0]          c2v_mag,
   output logic [MIN_INDEX_BITWIDTH-1:0] c2v_index,
   output logic                          c2v_last
);

   import ldpc_cnu_pkg::*;

`ifdef OFFSET_MS_EN
   localparam int unsigned EFF_OFFSET = OFFSET;
`else
   // Offset disabled: subtracting zero leaves the selection unmodified.
   localparam int unsigned EFF_OFFSET = OFFSET * 0;
`endif

   localparam logic [MIN_INDEX_BITWIDTH-1:0] LAST_IDX = MIN_INDEX_BITWIDTH'(CN_DEGREE - 1);

   // Saturating subtract applied to both minima at capture, so the
   // per-edge select downstream stays a plain mux.
   function automatic logic [QUAN_SIZE-1:0] sat_sub(input logic [QUAN_SIZE-1:0] v);
      if (32'(v) > EFF_OFFSET) return v - QUAN_SIZE'(EFF_OFFSET);
      return '0;
   endfunction

   cnu_state_t                    state_q, state_d;
   logic [MIN_INDEX_BITWIDTH-1:0] cnt_q, cnt_d;
   logic [QUAN_SIZE-1:0]          m1_q, m2_q;
   logic [MIN_INDEX_BITWIDTH-1:0] idx_q;
   logic [CN_DEGREE-1:0]          sgn_q;
   logic                          parity_q;

   logic                          streaming;
   logic                          last_edge;
   logic                          handshake;
   logic                          capture;
   logic                          sel_sign;
   logic [QUAN_SIZE-1:0]          sel_mag;

   assign streaming = (state_q == STREAM);
   assign last_edge = streaming && (cnt_q == LAST_IDX);
   assign handshake = streaming && out_ready;
   assign in_ready  = !streaming || (last_edge && out_ready);
   assign capture   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (capture) begin
         state_d = STREAM;
         cnt_d   = '0;
      end else if (handshake) begin
         if (last_edge) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         m1_q     <= '0;
         m2_q     <= '0;
         idx_q    <= '0;
         sgn_q    <= '0;
         parity_q <= 1'b0;
      end else if (capture) begin
         m1_q     <= sat_sub(m1);
         m2_q     <= sat_sub(m2);
         idx_q    <= min_1_index;
         sgn_q    <= v2c_sign;
         parity_q <= ^v2c_sign;
      end
   end

   c2v_mag_sel #(
      .QUAN_SIZE          (QUAN_SIZE),
      .MIN_INDEX_BITWIDTH (MIN_INDEX_BITWIDTH)
   ) u_mag_sel (
      .cnt_i         (cnt_q),
      .min_1_index_i (idx_q),
      .m1_i          (m1_q),
      .m2_i          (m2_q),
      .parity_i      (parity_q),
      .sign_bit_i    (sgn_q[cnt_q]),
      .sign_o        (sel_sign),
      .mag_o         (sel_mag)
   );

   // Capture registers keep the previous CN after draining; gate so idle outputs read 0.
   assign out_valid = streaming;
   assign c2v_sign  = streaming && sel_sign;
   assign c2v_mag   = streaming ? sel_mag : '0;
   assign c2v_index = streaming ? cnt_q : '0;
   assign c2v_last  = last_edge;

endmodule

// File: tb/tb_c2v_msg_gen_10.sv
// Scoreboard bench for c2v_msg_gen_10: expected edges queued at capture,
// checked as each handshake completes.
module tb_c2v_msg_gen_10;

   import ldpc_cnu_pkg::*;

   localparam int unsigned DEG = 10;
   localparam int unsigned QW  = 3;
   localparam int unsigned IW  = 4;
`ifdef OFFSET_MS_EN
   localparam int unsigned TB_OFFSET = 1;
`else
   localparam int unsigned TB_OFFSET = 0;
`endif

   logic          sys_clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [QW-1:0] m1, m2;
   logic [IW-1:0] min_1_index;
   logic [DEG-1:0] v2c_sign;
   logic          out_valid;
   logic          out_ready;
   logic          c2v_sign;
   logic [QW-1:0] c2v_mag;
   logic [IW-1:0] c2v_index;
   logic          c2v_last;

   c2v_msg_gen_10 #(
      .CN_DEGREE          (DEG),
      .QUAN_SIZE          (QW),
      .MIN_INDEX_BITWIDTH (IW),
      .OFFSET             (1)
   ) dut (
      .sys_clk     (sys_clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .m1          (m1),
      .m2          (m2),
      .min_1_index (min_1_index),
      .v2c_sign    (v2c_sign),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .c2v_sign    (c2v_sign),
      .c2v_mag     (c2v_mag),
      .c2v_index   (c2v_index),
      .c2v_last    (c2v_last)
   );

   always #5 sys_clk = ~sys_clk;

   c2v_msg_t    exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_hs = 0;
   int unsigned n_cycle = 0;
   int unsigned first_hs, last_hs;
   bit          ready_pattern = 1'b0;
   int unsigned ready_phase = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic c2v_msg_t model(input logic [QW-1:0] a, input logic [QW-1:0] b,
                                      input logic [IW-1:0] mi, input logic [DEG-1:0] s,
                                      input int unsigned e);
      c2v_msg_t    r;
      int unsigned sel;
      sel     = (int'(mi) == int'(e)) ? int'(b) : int'(a);
      r.mag   = (sel > TB_OFFSET) ? QW'(sel - TB_OFFSET) : '0;
      r.sign  = (^s) ^ s[e];
      r.index = IW'(e);
      r.last  = (e == DEG - 1);
      return r;
   endfunction

   // out_ready driver: steady 1, or the 1,0,0,1 backpressure pattern
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         if (ready_pattern) begin
            out_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
            ready_phase++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: hold-stability under stall and scoreboard pop on handshake
   initial begin
      logic       stall_q;
      logic [8:0] held;
      c2v_msg_t   e;
      stall_q = 1'b0;
      held    = '0;
      forever begin
         @(negedge sys_clk);
         n_cycle++;
         if (!rstn) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q && out_valid)
               chk("hold_stable", {c2v_sign, c2v_mag, c2v_index, c2v_last}, held);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", {28'd0, c2v_index}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("c2v_index", c2v_index, e.index);
                  chk("c2v_sign",  c2v_sign,  e.sign);
                  chk("c2v_mag",   c2v_mag,   e.mag);
                  chk("c2v_last",  c2v_last,  e.last);
                  if (n_hs == 0 || first_hs == 0) first_hs = n_cycle;
                  last_hs = n_cycle;
                  n_hs++;
               end
            end
            stall_q = out_valid && !out_ready;
            held    = {c2v_sign, c2v_mag, c2v_index, c2v_last};
         end
      end
   end

   task automatic send_cn(input logic [QW-1:0] a, input logic [QW-1:0] b,
                          input logic [IW-1:0] mi, input logic [DEG-1:0] s);
      bit got;
      got = 1'b0;
      @(posedge sys_clk);
      #1;
      in_valid = 1'b1; m1 = a; m2 = b; min_1_index = mi; v2c_sign = s;
      for (int c = 0; c < 200; c++) begin
         @(negedge sys_clk);
         if (in_ready) begin
            for (int unsigned k = 0; k < DEG; k++) exp_q.push_back(model(a, b, mi, s, k));
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("capture_timeout", 0, 1);
      @(posedge sys_clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain_and_idle(input string tag);
      for (int c = 0; c < 300; c++) begin
         @(negedge sys_clk);
         if (exp_q.size() == 0) break;
      end
      chk({tag, "_drained"}, exp_q.size(), 0);
      @(negedge sys_clk);
      chk({tag, "_idle_valid"}, out_valid, 0);
      chk({tag, "_idle_ready"}, in_ready, 1);
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; m1 = '0; m2 = '0; min_1_index = '0; v2c_sign = '0;
      first_hs = 0; last_hs = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_outputs", {c2v_sign, c2v_mag, c2v_index, c2v_last}, 0);
      repeat (3) @(negedge sys_clk);
      rstn = 1'b1;

      // 1: single CN, continuous ready
      n_hs = 0; first_hs = 0;
      send_cn(3'd1, 3'd3, 4'd4, 10'b00_0000_0001);
      drain_and_idle("t1");
      chk("t1_span", last_hs - first_hs, DEG - 1);

      // 2: backpressure 1,0,0,1
      ready_pattern = 1'b1; ready_phase = 0; n_hs = 0;
      send_cn(3'd1, 3'd3, 4'd4, 10'b00_0000_0001);
      drain_and_idle("t2");
      chk("t2_hs_count", n_hs, DEG);
      ready_pattern = 1'b0;
      repeat (2) @(negedge sys_clk);

      // 3: back-to-back CNs without bubble
      n_hs = 0; first_hs = 0;
      send_cn(3'd1, 3'd3, 4'd4, 10'b00_0000_0001);
      send_cn(3'd2, 3'd5, 4'd9, 10'b00_0000_0000);
      drain_and_idle("t3");
      chk("t3_hs_count", n_hs, 2 * DEG);
      chk("t3_span", last_hs - first_hs, 2 * DEG - 1);

      // 6: illegal min index selects m1 everywhere
      send_cn(3'd2, 3'd6, 4'd12, 10'b10_1100_0110);
      drain_and_idle("t6");

      // randomised CNs under backpressure
      ready_pattern = 1'b1;
      for (int r = 0; r < 3; r++)
         send_cn(QW'($urandom_range(7)), QW'($urandom_range(7)),
                 IW'($urandom_range(9)), DEG'($urandom));
      drain_and_idle("trand");
      ready_pattern = 1'b0;

`ifdef OFFSET_MS_EN
      // 5: offset saturation
      send_cn(3'd0, 3'd1, 4'd0, 10'b00_0000_0000);
      send_cn(3'd3, 3'd7, 4'd2, 10'b01_0010_0000);
      drain_and_idle("t5");
`endif

      // 4: asynchronous reset during edge 5
      begin
         bit seen;
         seen = 1'b0;
         send_cn(3'd1, 3'd3, 4'd4, 10'b00_0000_0001);
         for (int c = 0; c < 50; c++) begin
            @(negedge sys_clk);
            if (out_valid && c2v_index == 4'd5) begin
               seen = 1'b1;
               break;
            end
         end
         chk("t4_reach_edge5", seen, 1);
         #1;
         rstn = 1'b0;
         #1;
         chk("t4_rst_out_valid", out_valid, 0);
         chk("t4_rst_in_ready",  in_ready,  1);
         exp_q.delete();
         @(negedge sys_clk);
         rstn = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            chk("t4_no_output", out_valid, 0);
         end
         send_cn(3'd4, 3'd2, 4'd7, 10'b11_0000_0011);
         drain_and_idle("t4_after");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

endmodule
